// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: shared DRP widths, FSM states and table entry type for the MMCM reconfig controller
package mmcm_drp_pkg;
  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;
  typedef enum logic [3:0] {
    IDLE, HOLD_RST, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK, DONE
  } drp_state_e;
  typedef struct packed {
    logic [DRP_AW-1:0] addr;
    logic [DRP_DW-1:0] mask;
    logic [DRP_DW-1:0] data;
  } drp_entry_t;
endpackage

// File: rtl/mmcm_drp_table.sv
// mmcm_drp_table: NUM_ENTRIES x drp_entry_t register file, one write port, one async read port, sync clear
module mmcm_drp_table import mmcm_drp_pkg::*; #(
  parameter int NUM_ENTRIES = 8,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic          sysClk_i,
  input  logic          sysRst_i,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  drp_entry_t    wentry,
  input  logic [IW-1:0] ridx,
  output drp_entry_t    rentry
);
  drp_entry_t mem [NUM_ENTRIES];
  always_ff @(posedge sysClk_i)
    if (sysRst_i) for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
    else if (we) mem[widx] <= wentry;
  assign rentry = mem[ridx];
endmodule

// File: rtl/mmcm_drp_reconfig_ctrl.sv
// mmcm_drp_reconfig_ctrl: holds MMCM in reset, read-modify-writes a DRP table, waits for stable lock; MMCM_DRP_TIMEOUT_EN adds a wait-state watchdog
module mmcm_drp_reconfig_ctrl import mmcm_drp_pkg::*; #(
  parameter int NUM_ENTRIES = 8,
  parameter int LOCK_STABLE = 64,
  parameter int RST_HOLD    = 4,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic              sysClk_i,
  input  logic              sysRst_i,
  input  logic              tblWe_i,
  input  logic [IW-1:0]     tblIdx_i,
  input  logic [DRP_AW-1:0] tblAddr_i,
  input  logic [DRP_DW-1:0] tblMask_i,
  input  logic [DRP_DW-1:0] tblData_i,
  input  logic [IW:0]       numEntries_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DRP_AW-1:0] drpDaddr_o,
  output logic              drpDen_o,
  output logic              drpDwe_o,
  output logic [DRP_DW-1:0] drpDi_o,
  input  logic [DRP_DW-1:0] drpDo_i,
  input  logic              drpDrdy_i,
  output logic              mmcmRst_o,
  input  logic              mmcmLocked_i
);
  localparam int CW = $clog2(LOCK_STABLE + RST_HOLD + 1);
  localparam logic [IW:0] NMAX = (IW+1)'(NUM_ENTRIES);
  drp_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW:0] idx, n, n_in;
  logic [DRP_DW-1:0] do_q;
  logic [1:0] lk_s;
  logic lk, timeout;
  drp_entry_t ent, wentry;
  assign wentry = '{addr: tblAddr_i, mask: tblMask_i, data: tblData_i};
  mmcm_drp_table #(.NUM_ENTRIES(NUM_ENTRIES)) u_table (
    .sysClk_i(sysClk_i), .sysRst_i(sysRst_i), .we(tblWe_i && !busy_o), .widx(tblIdx_i),
    .wentry(wentry), .ridx(idx[IW-1:0]), .rentry(ent)
  );
  assign lk = lk_s[1];
  assign n_in = numEntries_i > NMAX ? NMAX : numEntries_i;
  assign busy_o = state inside {HOLD_RST, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK};
  assign done_o = state == DONE;
  assign mmcmRst_o = state inside {HOLD_RST, RD, WAIT_RD, WR, WAIT_WR};
  assign drpDen_o = state inside {RD, WR};
  assign drpDwe_o = state == WR;
  assign drpDaddr_o = drpDen_o ? ent.addr : '0;
  assign drpDi_o = drpDwe_o ? (do_q & ent.mask) | (ent.data & ~ent.mask) : '0;
`ifdef MMCM_DRP_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd;
  logic err_q, wait_st;
  assign wait_st = state inside {WAIT_RD, WAIT_WR, WAIT_LOCK};
  assign timeout = wait_st && wd == WW'(TIMEOUT_CYC - 1);
  assign err_o = err_q;
  always_ff @(posedge sysClk_i)
    if (sysRst_i) begin
      wd <= '0;
      err_q <= 1'b0;
    end else begin
      wd <= state_d != state ? '0 : wd + WW'(wait_st);
      err_q <= (state == IDLE && start_i) ? 1'b0 : (err_q || timeout);
    end
`else
  assign timeout = 1'b0;
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    case (state)
      IDLE:      state_d = start_i ? (n_in == '0 ? DONE : HOLD_RST) : IDLE;
      HOLD_RST:  state_d = cnt == CW'(RST_HOLD - 1) ? RD : HOLD_RST;
      RD:        state_d = WAIT_RD;
      WAIT_RD:   state_d = drpDrdy_i ? WR : WAIT_RD;
      WR:        state_d = WAIT_WR;
      WAIT_WR:   state_d = drpDrdy_i ? (idx + 1'b1 < n ? RD : RELEASE) : WAIT_WR;
      RELEASE:   state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        cnt_d = lk ? cnt + 1'b1 : '0;
        state_d = lk && cnt == CW'(LOCK_STABLE - 1) ? DONE : WAIT_LOCK;
      end
      default:   state_d = IDLE;
    endcase
    if (timeout) state_d = DONE;
    if (state_d != state) cnt_d = '0;
  end
  always_ff @(posedge sysClk_i)
    if (sysRst_i) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      n <= '0;
      do_q <= '0;
      lk_s <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      lk_s <= {lk_s[0], mmcmLocked_i};
      if (state == IDLE && start_i) begin
        n <= n_in;
        idx <= '0;
      end
      if (state == WAIT_RD && drpDrdy_i) do_q <= drpDo_i;
      if (state == WAIT_WR && drpDrdy_i) idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// tb_mmcm_drp_reconfig_ctrl: directed self-checking bench with a behavioural DRP slave
module tb_mmcm_drp_reconfig_ctrl;
  logic clk, rst, tbl_we, start, den, dwe, drdy, mrst, locked, busy, done, err;
  logic [2:0] tbl_idx;
  logic [6:0] tbl_addr, daddr;
  logic [15:0] tbl_mask, tbl_data, di, dout;
  logic [3:0] num_ent;
  logic [15:0] mem [128];
  logic [6:0] rd_a [$];
  logic [6:0] wr_a [$];
  logic [15:0] wr_d [$];
  int done_cnt, rst_cnt, den_cnt, rst_bad, pend, vecs, miss, ts, tr;
  bit no_rdy;

  mmcm_drp_reconfig_ctrl dut (
    .sysClk_i(clk), .sysRst_i(rst), .tblWe_i(tbl_we), .tblIdx_i(tbl_idx), .tblAddr_i(tbl_addr),
    .tblMask_i(tbl_mask), .tblData_i(tbl_data), .numEntries_i(num_ent), .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err), .drpDaddr_o(daddr), .drpDen_o(den),
    .drpDwe_o(dwe), .drpDi_o(di), .drpDo_i(dout), .drpDrdy_i(drdy), .mmcmRst_o(mrst),
    .mmcmLocked_i(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    drdy = 1'b0;
    dout = '0;
    pend = 0;
    forever begin
      @(negedge clk);
      drdy = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) drdy = 1'b1;
      end
      if (den) begin
        den_cnt++;
        if (!mrst) rst_bad++;
        if (dwe) begin
          mem[daddr] = di;
          wr_a.push_back(daddr);
          wr_d.push_back(di);
        end else begin
          dout = mem[daddr];
          rd_a.push_back(daddr);
        end
        pend = no_rdy ? 0 : 2;
      end
      if (done) done_cnt++;
      if (mrst) rst_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tbl_wr(input logic [2:0] i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    tbl_we = 1'b1; tbl_idx = i; tbl_addr = a; tbl_mask = m; tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic clr_logs();
    rd_a.delete(); wr_a.delete(); wr_d.delete();
    done_cnt = 0; rst_cnt = 0; den_cnt = 0; rst_bad = 0;
  endtask

  task automatic run(input logic [3:0] ne, input int glitch, output int t_start, output int t_rel);
    int k, rel;
    bit saw;
    num_ent = ne;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tbl_we = 1'b0;
    k = 1; rel = -1; saw = 0;
    while (!done && k < 8000) begin
      if (mrst) saw = 1;
      else if (saw && rel < 0) rel = 0;
      if (rel >= 0) locked = (rel == glitch) ? 1'b0 : 1'b1;
      @(negedge clk);
      k++;
      if (rel >= 0) rel++;
    end
    chk("done_reached", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    t_start = k;
    t_rel = rel;
    @(negedge clk);
  endtask

  initial begin
    vecs = 0; miss = 0; no_rdy = 0;
    rst = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_mask = '0; tbl_data = '0;
    num_ent = '0; start = 1'b0; locked = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    clr_logs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_den_dwe", 32'({den, dwe}), 0);
    chk("rst_addr_di", 32'({daddr, di}), 0);
    chk("rst_mmcm", 32'(mrst), 0);
    @(negedge clk);

    mem[7'h08] = 16'hFFFF;
    mem[7'h0A] = 16'h1234;
    tbl_wr(3'd0, 7'h08, 16'h1000, 16'h0145);
    tbl_wr(3'd1, 7'h0A, 16'hFFFF, 16'h0000);
    clr_logs();
    num_ent = 4'd2;
    start = 1'b1;
    @(negedge clk);
    chk("t1_busy_after_start", 32'(busy), 1);
    chk("t1_rst_after_start", 32'(mrst), 1);
    start = 1'b0;
    while (busy && den_cnt < 100) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t1_wr_count", 32'(wr_a.size()), 2);
    chk("t1_rd0_addr", 32'(rd_a[0]), 32'h08);
    chk("t1_wr0_addr", 32'(wr_a[0]), 32'h08);
    chk("t1_wr0_data", 32'(wr_d[0]), 32'h1145);
    chk("t1_rd1_addr", 32'(rd_a[1]), 32'h0A);
    chk("t1_wr1_addr", 32'(wr_a[1]), 32'h0A);
    chk("t1_wr1_data", 32'(wr_d[1]), 32'h1234);
    chk("t1_rst_during_drp", 32'(rst_bad), 0);
    chk("t1_done_once", 32'(done_cnt), 1);

    clr_logs();
    run(4'd2, -1, ts, tr);
    chk("t1b_start_to_done", 32'(ts), 82);
    chk("t1b_release_to_done", 32'(tr), 65);

    clr_logs();
    run(4'd0, -1, ts, tr);
    chk("t2_done_next_cycle", 32'(ts), 1);
    chk("t2_no_den", 32'(den_cnt), 0);
    chk("t2_no_mmcm_rst", 32'(rst_cnt), 0);
    chk("t2_done_once", 32'(done_cnt), 1);

    for (int i = 0; i < 8; i++) mem[7'h10 + i] = 16'h5A5A;
    for (int i = 0; i < 7; i++) tbl_wr(3'(i), 7'(7'h10 + i), 16'hFF00, 16'(16'h1200 + i));
    clr_logs();
    tbl_we = 1'b1; tbl_idx = 3'd7; tbl_addr = 7'h17; tbl_mask = 16'hFF00; tbl_data = 16'h1207;
    run(4'd15, -1, ts, tr);
    chk("t3_wr_count", 32'(wr_a.size()), 8);
    chk("t3_start_to_done", 32'(ts), 118);
    for (int i = 0; i < 8; i++) begin
      chk("t3_rd_addr", 32'(rd_a[i]), 32'(7'h10 + i));
      chk("t3_wr_addr", 32'(wr_a[i]), 32'(7'h10 + i));
      chk("t3_wr_data", 32'(wr_d[i]), 32'(16'h5A00 + i));
    end

    clr_logs();
    run(4'd1, 29, ts, tr);
    chk("t4_glitch_release_to_done", 32'(tr), 96);
    chk("t4_done_once", 32'(done_cnt), 1);

    tbl_wr(3'd0, 7'h20, 16'h0000, 16'h1357);
    num_ent = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !dwe; i++) @(negedge clk);
    chk("t5_reached_wr", 32'(dwe), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_state_idle", 32'(dut.state), 0);
    chk("t5_outputs_zero", 32'({busy, done, err, den, dwe, mrst}), 0);
    chk("t5_addr_di_zero", 32'({daddr, di}), 0);
    repeat (4) @(negedge clk);
    mem[0] = 16'hBEEF;
    clr_logs();
    run(4'd8, -1, ts, tr);
    chk("t5_wr_count", 32'(wr_a.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t5_rd_addr", 32'(rd_a[i]), 0);
      chk("t5_wr_addr", 32'(wr_a[i]), 0);
      chk("t5_wr_data", 32'(wr_d[i]), 0);
    end

`ifdef MMCM_DRP_TIMEOUT_EN
    no_rdy = 1;
    clr_logs();
    run(4'd1, -1, ts, tr);
    chk("t6_timeout_latency", 32'(ts), 4102);
    chk("t6_err_set", 32'(err), 1);
    chk("t6_mmcm_rst_low", 32'(mrst), 0);
    chk("t6_done_once", 32'(done_cnt), 1);
    no_rdy = 0;
    num_ent = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_err_cleared", 32'(err), 0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
